// File: rtl/video_ram_slot_controller_if.sv
`default_nettype none
// ============================================================================
// Module   : video_ram_slot_controller_if
// Brief    : Timing-chain / CPU / DRAM signal bundle for the slot controller.
// Revision : 1.0 - initial release
// ============================================================================
interface video_ram_slot_controller_if #(
  parameter int ADDR_W = 14,
  parameter int MA_W   = 7
);
  logic              SLOT_SYNC;
  logic              VIDEO_ACTIVE;
  logic [ADDR_W-1:0] VID_ADDR;
  logic              CPU_REQ;
  logic              CPU_WR;
  logic [ADDR_W-1:0] CPU_ADDR;
  logic [MA_W-1:0]   VRAM_MA;
  logic              RAS_AL;
  logic              CAS_AL;
  logic              WE_AL;
  logic              VID_LOAD;
  logic              CPU_DONE;
  logic              CPU_WAIT_AL;

  modport master (
    output SLOT_SYNC, VIDEO_ACTIVE, VID_ADDR, CPU_REQ, CPU_WR, CPU_ADDR,
    input  VRAM_MA, RAS_AL, CAS_AL, WE_AL, VID_LOAD, CPU_DONE, CPU_WAIT_AL
  );

  modport slave (
    input  SLOT_SYNC, VIDEO_ACTIVE, VID_ADDR, CPU_REQ, CPU_WR, CPU_ADDR,
    output VRAM_MA, RAS_AL, CAS_AL, WE_AL, VID_LOAD, CPU_DONE, CPU_WAIT_AL
  );
endinterface
`default_nettype wire

// File: rtl/video_ram_slot_controller.sv
`default_nettype none
// ============================================================================
// Module   : video_ram_slot_controller
// Brief    : Arbitrated 4-clock DRAM slot sequencer shared by video and CPU.
// Revision : 1.0 - initial release
// ============================================================================
module video_ram_slot_controller #(
  parameter int ADDR_W = 14,
  parameter int MA_W   = 7
) (
  input  wire logic                  CLOCK_10MHZ,
  input  wire logic                  RESET,
  video_ram_slot_controller_if.slave bus
);

  typedef enum logic [1:0] {
    S_ARB = 2'd0,
    S_RAS = 2'd1,
    S_CAS = 2'd2,
    S_END = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    OWN_IDLE = 2'd0,
    OWN_VID  = 2'd1,
    OWN_CPU  = 2'd2
  } owner_t;

  state_t            r_state;
  state_t            w_state_nxt;
  owner_t            r_owner;
  owner_t            w_owner_nxt;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W-1:0] w_addr_nxt;
  logic              r_wr;
  logic              w_wr_nxt;
  logic              r_toggle;
  logic              w_toggle_nxt;
  logic              r_disarm;
  logic              w_disarm_nxt;
  logic              w_armed;
  logic              w_busy;

  logic [MA_W-1:0]   r_ma;
  logic [MA_W-1:0]   w_ma_nxt;
  logic              r_ras_al;
  logic              w_ras_al_nxt;
  logic              r_cas_al;
  logic              w_cas_al_nxt;
  logic              r_we_al;
  logic              w_we_al_nxt;
  logic              r_vid_load;
  logic              w_vid_load_nxt;
  logic              r_cpu_done;
  logic              w_cpu_done_nxt;
  logic              r_wait_al;
  logic              w_wait_al_nxt;

  // A held request stays disarmed after completion until CPU_REQ is seen low.
  assign w_armed = bus.CPU_REQ & ~r_disarm;

  // Slot sequencing and arbitration; the owner is committed on leaving S_ARB.
  always_comb begin
    w_state_nxt  = r_state;
    w_owner_nxt  = r_owner;
    w_addr_nxt   = r_addr;
    w_wr_nxt     = r_wr;
    w_toggle_nxt = r_toggle;
    unique case (r_state)
      S_ARB: begin
        if (bus.SLOT_SYNC) begin
          w_state_nxt = S_ARB;
        end else begin
          w_state_nxt  = S_RAS;
          w_toggle_nxt = ~r_toggle;
          if (bus.VIDEO_ACTIVE && !r_toggle) begin
            w_owner_nxt = OWN_VID;
            w_addr_nxt  = bus.VID_ADDR;
            w_wr_nxt    = 1'b0;
          end else if (w_armed) begin
            w_owner_nxt = OWN_CPU;
            w_addr_nxt  = bus.CPU_ADDR;
            w_wr_nxt    = bus.CPU_WR;
          end else begin
            w_owner_nxt = OWN_IDLE;
            w_wr_nxt    = 1'b0;
          end
        end
      end
      S_RAS: begin
        if (bus.SLOT_SYNC) begin
          w_state_nxt = S_ARB;
        end else begin
          w_state_nxt = S_CAS;
        end
      end
      S_CAS: begin
        if (bus.SLOT_SYNC) begin
          w_state_nxt = S_ARB;
        end else begin
          w_state_nxt = S_END;
        end
      end
      S_END: begin
        w_state_nxt = S_ARB;
      end
      default: begin
        w_state_nxt = S_ARB;
      end
    endcase
  end

  // Outputs are decoded from the upcoming state so every pin leaves a flop.
  always_comb begin
    w_busy         = (w_owner_nxt != OWN_IDLE);
    w_ma_nxt       = w_addr_nxt[MA_W-1:0];
    w_ras_al_nxt   = 1'b1;
    w_cas_al_nxt   = 1'b1;
    w_we_al_nxt    = 1'b1;
    w_vid_load_nxt = 1'b0;
    w_cpu_done_nxt = 1'b0;
    unique case (w_state_nxt)
      S_ARB: begin
        w_ras_al_nxt = 1'b1;
      end
      S_RAS: begin
        w_ras_al_nxt = ~w_busy;
        w_we_al_nxt  = ~(w_busy & w_wr_nxt);
      end
      S_CAS: begin
        w_ma_nxt     = w_addr_nxt[ADDR_W-1:MA_W];
        w_ras_al_nxt = ~w_busy;
        w_cas_al_nxt = ~w_busy;
        w_we_al_nxt  = ~(w_busy & w_wr_nxt);
      end
      S_END: begin
        w_ma_nxt       = w_addr_nxt[ADDR_W-1:MA_W];
        w_ras_al_nxt   = ~w_busy;
        w_cas_al_nxt   = ~w_busy;
        w_we_al_nxt    = ~(w_busy & w_wr_nxt);
        w_vid_load_nxt = (w_owner_nxt == OWN_VID);
        w_cpu_done_nxt = (w_owner_nxt == OWN_CPU);
      end
      default: begin
        w_ras_al_nxt = 1'b1;
      end
    endcase

    if (w_cpu_done_nxt) begin
      w_disarm_nxt = 1'b1;
    end else if (!bus.CPU_REQ) begin
      w_disarm_nxt = 1'b0;
    end else begin
      w_disarm_nxt = r_disarm;
    end
    w_wait_al_nxt = ~(bus.CPU_REQ & ~w_disarm_nxt);
  end

  always_ff @(posedge CLOCK_10MHZ or posedge RESET) begin
    if (RESET) begin
      r_state  <= S_ARB;
      r_owner  <= OWN_IDLE;
      r_addr   <= '0;
      r_wr     <= 1'b0;
      r_toggle <= 1'b0;
      r_disarm <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_owner  <= w_owner_nxt;
      r_addr   <= w_addr_nxt;
      r_wr     <= w_wr_nxt;
      r_toggle <= w_toggle_nxt;
      r_disarm <= w_disarm_nxt;
    end
  end

  always_ff @(posedge CLOCK_10MHZ or posedge RESET) begin
    if (RESET) begin
      r_ma       <= '0;
      r_ras_al   <= 1'b1;
      r_cas_al   <= 1'b1;
      r_we_al    <= 1'b1;
      r_vid_load <= 1'b0;
      r_cpu_done <= 1'b0;
      r_wait_al  <= 1'b1;
    end else begin
      r_ma       <= w_ma_nxt;
      r_ras_al   <= w_ras_al_nxt;
      r_cas_al   <= w_cas_al_nxt;
      r_we_al    <= w_we_al_nxt;
      r_vid_load <= w_vid_load_nxt;
      r_cpu_done <= w_cpu_done_nxt;
      r_wait_al  <= w_wait_al_nxt;
    end
  end

  assign bus.VRAM_MA     = r_ma;
  assign bus.RAS_AL      = r_ras_al;
  assign bus.CAS_AL      = r_cas_al;
  assign bus.WE_AL       = r_we_al;
  assign bus.VID_LOAD    = r_vid_load;
  assign bus.CPU_DONE    = r_cpu_done;
  assign bus.CPU_WAIT_AL = r_wait_al;

endmodule
`default_nettype wire

// File: tb/tb_video_ram_slot_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_video_ram_slot_controller
// Brief    : Directed vector bench for the video RAM slot controller.
// Revision : 1.0 - initial release
// ============================================================================
module tb_video_ram_slot_controller;

  localparam logic [13:0] C_A  = {7'h35, 7'h1A};
  localparam logic [13:0] C_B  = {7'h0F, 7'h70};
  localparam logic [13:0] C_CR = 14'h2A55;
  localparam logic [13:0] C_CW = {7'h12, 7'h6B};

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  video_ram_slot_controller_if #(.ADDR_W(14), .MA_W(7)) bus ();

  video_ram_slot_controller #(
    .ADDR_W (14),
    .MA_W   (7)
  ) dut (
    .CLOCK_10MHZ (clk),
    .RESET       (rst),
    .bus         (bus)
  );

  typedef struct {
    logic        sync;
    logic        va;
    logic [13:0] vaddr;
    logic        req;
    logic        wr;
    logic [13:0] caddr;
    logic        ma_chk;
    logic [6:0]  ma;
    logic        ras;
    logic        cas;
    logic        we;
    logic        vl;
    logic        cd;
    logic        wt;
  } vec_t;

  vec_t vecs[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic addv(input logic sync, input logic va, input logic [13:0] vaddr,
                      input logic req, input logic wr, input logic [13:0] caddr,
                      input logic ma_chk, input logic [6:0] ma,
                      input logic ras, input logic cas, input logic we,
                      input logic vl, input logic cd, input logic wt);
    vec_t v;
    v.sync = sync; v.va = va; v.vaddr = vaddr; v.req = req; v.wr = wr; v.caddr = caddr;
    v.ma_chk = ma_chk; v.ma = ma; v.ras = ras; v.cas = cas; v.we = we;
    v.vl = vl; v.cd = cd; v.wt = wt;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic sync, input logic va, input logic [13:0] vaddr,
                       input logic req, input logic wr, input logic [13:0] caddr);
    bus.SLOT_SYNC    = sync;
    bus.VIDEO_ACTIVE = va;
    bus.VID_ADDR     = vaddr;
    bus.CPU_REQ      = req;
    bus.CPU_WR       = wr;
    bus.CPU_ADDR     = caddr;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Packed as {MA[6:0], RAS, CAS, WE, VID_LOAD, CPU_DONE, WAIT}.
  task automatic check(input string name, input logic ma_chk, input logic [6:0] ma,
                       input logic ras, input logic cas, input logic we,
                       input logic vl, input logic cd, input logic wt);
    logic [12:0] act;
    logic [12:0] exp;
    logic [12:0] mask;
    act  = {bus.VRAM_MA, bus.RAS_AL, bus.CAS_AL, bus.WE_AL,
            bus.VID_LOAD, bus.CPU_DONE, bus.CPU_WAIT_AL};
    exp  = {ma, ras, cas, we, vl, cd, wt};
    mask = {(ma_chk ? 7'h7F : 7'h00), 6'h3F};
    checks++;
    if ((act & mask) !== (exp & mask)) begin
      errors++;
      $display("FAIL %s: got {ma,ras,cas,we,vl,cd,wait}=%h_%b required %h_%b (ma checked=%0b)",
               name, act[12:6], act[5:0], exp[12:6], exp[5:0], ma_chk);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, required finish before timeout");
    $fatal(1);
  end

  initial begin
    checks = 0;
    errors = 0;

    // Slot 1: video fetch of C_A
    addv(0,1,C_A,0,0,14'h0, 1,7'h1A, 0,1,1,0,0,1);
    addv(0,1,C_A,0,0,14'h0, 1,7'h35, 0,0,1,0,0,1);
    addv(0,1,C_A,0,0,14'h0, 1,7'h35, 0,0,1,1,0,1);
    addv(0,1,C_A,0,0,14'h0, 0,7'h00, 1,1,1,0,0,1);
    // Slot 2: C slot, nothing requested
    for (int i = 0; i < 4; i++) addv(0,1,C_A,0,0,14'h0, 0,7'h00, 1,1,1,0,0,1);
    // Slot 3: video fetch of C_B
    addv(0,1,C_B,0,0,14'h0, 1,7'h70, 0,1,1,0,0,1);
    addv(0,1,C_B,0,0,14'h0, 1,7'h0F, 0,0,1,0,0,1);
    addv(0,1,C_B,0,0,14'h0, 1,7'h0F, 0,0,1,1,0,1);
    addv(0,1,C_B,0,0,14'h0, 0,7'h00, 1,1,1,0,0,1);
    // Slot 4: idle C slot
    for (int i = 0; i < 4; i++) addv(0,1,C_A,0,0,14'h0, 0,7'h00, 1,1,1,0,0,1);
    // Slot 5: V slot; CPU read arrives and must wait; VID_ADDR change is ignored
    addv(0,1,C_A,1,0,C_CR, 1,7'h1A, 0,1,1,0,0,0);
    addv(0,1,C_B,1,0,C_CR, 1,7'h35, 0,0,1,0,0,0);
    addv(0,1,C_B,1,0,C_CR, 1,7'h35, 0,0,1,1,0,0);
    addv(0,1,C_B,1,0,C_CR, 0,7'h00, 1,1,1,0,0,0);
    // Slot 6: C slot serves the read; CPU_ADDR change after S_ARB is ignored
    addv(0,1,C_B,1,0,C_CR, 1,7'h55, 0,1,1,0,0,0);
    addv(0,1,C_B,1,0,C_CW, 1,7'h54, 0,0,1,0,0,0);
    addv(0,1,C_B,1,0,C_CW, 1,7'h54, 0,0,1,0,1,1);
    addv(0,1,C_B,0,0,14'h0, 0,7'h00, 1,1,1,0,0,1);
    // Slot 7: blanking, held write
    addv(0,0,C_B,1,1,C_CW, 1,7'h6B, 0,1,0,0,0,0);
    addv(0,0,C_B,1,1,C_CW, 1,7'h12, 0,0,0,0,0,0);
    addv(0,0,C_B,1,1,C_CW, 1,7'h12, 0,0,0,0,1,1);
    addv(0,0,C_B,1,1,C_CW, 0,7'h00, 1,1,1,0,0,1);
    // Slots 8-9: request still held, must not be serviced again
    for (int i = 0; i < 7; i++) addv(0,0,C_B,1,1,C_CW, 0,7'h00, 1,1,1,0,0,1);
    // Drop for one clock, then rise in the S_ARB cycle of slot 10
    addv(0,0,C_B,0,0,C_CW, 0,7'h00, 1,1,1,0,0,1);
    addv(0,0,C_B,1,1,C_CW, 1,7'h6B, 0,1,0,0,0,0);
    addv(0,0,C_B,1,1,C_CW, 1,7'h12, 0,0,0,0,0,0);
    addv(0,0,C_B,1,1,C_CW, 1,7'h12, 0,0,0,0,1,1);
    addv(0,0,C_B,0,0,14'h0, 0,7'h00, 1,1,1,0,0,1);

    rst = 1'b1;
    drive(0, 1, C_A, 0, 0, 14'h0);
    #1;
    check("reset_values", 1, 7'h00, 1,1,1,0,0,1);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].sync, vecs[i].va, vecs[i].vaddr, vecs[i].req, vecs[i].wr, vecs[i].caddr);
      step();
      check($sformatf("vec%0d", i), vecs[i].ma_chk, vecs[i].ma, vecs[i].ras, vecs[i].cas,
            vecs[i].we, vecs[i].vl, vecs[i].cd, vecs[i].wt);
    end

    // SLOT_SYNC abort during S_CAS of a CPU read, then retry
    drive(0, 0, C_B, 1, 0, C_CR);
    step();
    check("abort_ras", 1, 7'h55, 0,1,1,0,0,0);
    step();
    check("abort_cas", 1, 7'h54, 0,0,1,0,0,0);
    drive(1, 0, C_B, 1, 0, C_CR);
    step();
    check("abort_strobes_high", 0, 7'h00, 1,1,1,0,0,0);
    drive(0, 0, C_B, 1, 0, C_CR);
    step();
    check("retry_ras", 1, 7'h55, 0,1,1,0,0,0);
    step();
    step();
    check("retry_done", 1, 7'h54, 0,0,1,0,1,1);
    drive(0, 0, C_B, 0, 0, 14'h0);
    step();
    check("retry_release", 0, 7'h00, 1,1,1,0,0,1);

    // Asynchronous reset during S_CAS of a CPU write
    drive(0, 0, C_B, 1, 1, C_CW);
    step();
    step();
    check("pre_reset_cas", 1, 7'h12, 0,0,0,0,0,0);
    #2;
    rst = 1'b1;
    #1;
    check("async_reset", 1, 7'h00, 1,1,1,0,0,1);
    drive(0, 1, C_A, 0, 0, 14'h0);
    step();
    check("reset_held", 1, 7'h00, 1,1,1,0,0,1);
    rst = 1'b0;
    step();
    check("post_reset_v_ras", 1, 7'h1A, 0,1,1,0,0,1);
    step();
    check("post_reset_v_cas", 1, 7'h35, 0,0,1,0,0,1);
    step();
    check("post_reset_v_load", 1, 7'h35, 0,0,1,1,0,1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
